// File: rtl/fsm_bluetooth.sv
// Shared state encodings and constants for the Bluetooth UART receive path.
package fsm_bluetooth;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } state_rx_bit;

  typedef enum logic {
    F_WAIT,
    F_DATA
  } state_rx_frame;

  localparam logic [7:0] DATA_MARKER = 8'h44;

endpackage

// File: rtl/bluetooth_rx.sv
// 8N1 UART receiver: 2-FF synchroniser on the line, then a bit-level FSM that
// centre-samples each bit and reports one byte (or a stop-bit error) per frame.
module bluetooth_rx
  import fsm_bluetooth::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);

  state_rx_bit   state;
  logic          sync1;
  logic          sync2;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  // Valid/ready contract: byte_valid and byte_err are single-cycle pulses with
  // no back-pressure; rx_byte holds the last good byte until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!sync2) state <= RX_START;
        end
        RX_START: begin
          // A start bit that is gone by mid-bit was a glitch.
          if (timer == HALF_BIT) begin
            timer <= '0;
            state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == LAST_CLK) begin
            timer   <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == LAST_CLK) begin
            timer <= '0;
            if (sync2) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              byte_err <= 1'b1;
              state    <= RX_CLEANUP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_CLEANUP: begin
          if (sync2) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/bluetooth_rx_handler.sv
// Bluetooth link receive handler: splits received bytes into commands and
// marker-prefixed data frames, assembling MSB-first samples with a wrapping index.
module bluetooth_rx_handler
  import fsm_bluetooth::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_BITS       = 32,
  parameter int N_SAMPLES    = 256,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         RX,
  output logic [7:0]                   out_cmd,
  output logic                         out_cmd_valid,
  output logic [N_BITS-1:0]            out_data,
  output logic                         out_data_valid,
  output logic [$clog2(N_SAMPLES)-1:0] out_index,
  output logic                         out_block_done,
  output logic                         out_frame_err,
  output logic                         out_busy
);

  localparam int IW    = $clog2(N_SAMPLES);
  localparam int BYTES = N_BITS / 8;
  localparam int BCW   = $clog2(BYTES + 1);
  localparam int TOW   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BYTES - 1);
  localparam logic [IW-1:0]  LAST_SAMPLE = IW'(N_SAMPLES - 1);
  localparam logic [TOW-1:0] TMO_LIMIT   = TOW'(TIMEOUT_CLKS);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_err;
  logic              rx_busy;
  state_rx_frame     frame_state;
  logic [BCW-1:0]    byte_cnt;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] acc_next;
  logic [IW-1:0]     sample_cnt;
  logic [TOW-1:0]    tmo;

  bluetooth_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RX),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .byte_err  (rx_err),
    .busy      (rx_busy)
  );

  // Truncating the concatenation shifts the oldest byte out of the top.
  assign acc_next = N_BITS'({acc, rx_byte});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state    <= F_WAIT;
      byte_cnt       <= '0;
      acc            <= '0;
      sample_cnt     <= '0;
      tmo            <= '0;
      out_cmd        <= '0;
      out_cmd_valid  <= 1'b0;
      out_data       <= '0;
      out_data_valid <= 1'b0;
      out_index      <= '0;
      out_block_done <= 1'b0;
      out_frame_err  <= 1'b0;
    end else begin
      out_cmd_valid  <= 1'b0;
      out_data_valid <= 1'b0;
      out_block_done <= 1'b0;
      out_frame_err  <= 1'b0;
      if (rx_err) begin
        // A corrupted byte poisons any partial sample; commands are unaffected.
        out_frame_err <= 1'b1;
        frame_state   <= F_WAIT;
        byte_cnt      <= '0;
        acc           <= '0;
        tmo           <= '0;
      end else begin
        case (frame_state)
          F_WAIT: begin
            if (rx_valid) begin
              if (rx_byte == DATA_MARKER) begin
                byte_cnt    <= '0;
                acc         <= '0;
                tmo         <= '0;
                frame_state <= F_DATA;
              end else begin
                out_cmd       <= rx_byte;
                out_cmd_valid <= 1'b1;
              end
            end
          end
          F_DATA: begin
            if (rx_valid) begin
              tmo <= '0;
              acc <= acc_next;
              if (byte_cnt == LAST_BYTE) begin
                out_data       <= acc_next;
                out_index      <= sample_cnt;
                out_data_valid <= 1'b1;
                if (sample_cnt == LAST_SAMPLE) begin
                  sample_cnt     <= '0;
                  out_block_done <= 1'b1;
                end else begin
                  sample_cnt <= sample_cnt + 1'b1;
                end
                frame_state <= F_WAIT;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else if (tmo == TMO_LIMIT) begin
              out_frame_err <= 1'b1;
              tmo           <= '0;
              frame_state   <= F_WAIT;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          default: frame_state <= F_WAIT;
        endcase
      end
    end
  end

  assign out_busy = rx_busy || (frame_state == F_DATA);

endmodule

// File: tb/tb_bluetooth_rx_handler.sv
// Directed bench for bluetooth_rx_handler: serial byte driver, expected-event
// queue filled by the stimulus, and a monitor that pops on every output pulse.
module tb_bluetooth_rx_handler;

  localparam int CPB  = 4;
  localparam int NB   = 32;
  localparam int NS   = 4;
  localparam int TMO  = 100;
  localparam int IW   = 2;
  localparam int EW   = 2 + 1 + IW + NB;

  localparam logic [1:0] EV_CMD  = 2'd1;
  localparam logic [1:0] EV_DATA = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [7:0]    out_cmd;
  logic          out_cmd_valid;
  logic [NB-1:0] out_data;
  logic          out_data_valid;
  logic [IW-1:0] out_index;
  logic          out_block_done;
  logic          out_frame_err;
  logic          out_busy;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;

  bluetooth_rx_handler #(
    .CLKS_PER_BIT(CPB),
    .N_BITS      (NB),
    .N_SAMPLES   (NS),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RX            (rx),
    .out_cmd       (out_cmd),
    .out_cmd_valid (out_cmd_valid),
    .out_data      (out_data),
    .out_data_valid(out_data_valid),
    .out_index     (out_index),
    .out_block_done(out_block_done),
    .out_frame_err (out_frame_err),
    .out_busy      (out_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ev(input logic [1:0] t, input logic bd,
                                       input logic [IW-1:0] idx, input logic [NB-1:0] d);
    return {t, bd, idx, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_event(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h with empty queue", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_block_done && !out_data_valid) begin
      checks++;
      errors++;
      $display("FAIL block_done_alone: got 1 expected 0");
    end
    if (out_cmd_valid)  compare_event("cmd_event", ev(EV_CMD, 1'b0, '0, {24'd0, out_cmd}));
    if (out_data_valid) compare_event("data_event", ev(EV_DATA, out_block_done, out_index, out_data));
    if (out_frame_err)  compare_event("err_event", ev(EV_ERR, 1'b0, '0, '0));
  end

  // Driver tasks
  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [NB-1:0] w);
    send_byte(8'h44, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic push_data(input logic [NB-1:0] w, input logic [IW-1:0] idx, input logic bd);
    exp_q.push_back(ev(EV_DATA, bd, idx, w));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx     = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd", {56'd0, out_cmd}, 64'd0);
    check("reset_data", {32'd0, out_data}, 64'd0);
    check("reset_index", {62'd0, out_index}, 64'd0);
    check("reset_pulses", {59'd0, out_cmd_valid, out_data_valid, out_block_done, out_frame_err, out_busy}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Command byte
    exp_q.push_back(ev(EV_CMD, 1'b0, '0, 32'h53));
    send_byte(8'h53, 1'b1);
    repeat (4) @(posedge clk);
    check("cmd_value", {56'd0, out_cmd}, 64'h53);
    check("cmd_data_unchanged", {32'd0, out_data}, 64'd0);

    // First data frame and block wrap
    push_data(32'hDEADBEEF, 2'd0, 1'b0);
    send_frame(32'hDEADBEEF);
    push_data(32'h01020304, 2'd1, 1'b0);
    send_frame(32'h01020304);
    push_data(32'h44444444, 2'd2, 1'b0);
    send_frame(32'h44444444);
    push_data(32'h80FF007F, 2'd3, 1'b1);
    send_frame(32'h80FF007F);
    push_data(32'h13579BDF, 2'd0, 1'b0);
    send_frame(32'h13579BDF);
    repeat (4) @(posedge clk);
    check("frame_data_hold", {32'd0, out_data}, 64'h13579BDF);

    // Command must not disturb data outputs
    exp_q.push_back(ev(EV_CMD, 1'b0, '0, 32'h21));
    send_byte(8'h21, 1'b1);
    repeat (4) @(posedge clk);
    check("cmd2_data_hold", {32'd0, out_data}, 64'h13579BDF);
    check("cmd2_index_hold", {62'd0, out_index}, 64'd0);

    // Timeout inside a frame, then 0x44 as a payload byte
    send_byte(8'h44, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    check("busy_in_frame", {63'd0, out_busy}, 64'd1);
    exp_q.push_back(ev(EV_ERR, 1'b0, '0, '0));
    repeat (120) @(posedge clk);
    @(negedge clk);
    check("busy_after_timeout", {63'd0, out_busy}, 64'd0);
    push_data(32'h00000044, 2'd1, 1'b0);
    send_frame(32'h00000044);

    // Bad stop bit mid-frame drops the partial sample
    send_byte(8'h44, 1'b1);
    send_byte(8'h11, 1'b1);
    exp_q.push_back(ev(EV_ERR, 1'b0, '0, '0));
    send_byte(8'h22, 1'b0);
    repeat (4) @(posedge clk);
    push_data(32'hA1B2C3D4, 2'd2, 1'b0);
    send_frame(32'hA1B2C3D4);

    // One-clock glitch produces nothing
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1 rx = 1'b0;
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", {63'd0, out_busy}, 64'd0);
    check("glitch_cmd_hold", {56'd0, out_cmd}, 64'h21);

    // Reset in the middle of a data frame byte
    send_byte(8'h44, 1'b1);
    send_byte(8'hAA, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", {63'd0, out_busy}, 64'd0);
    check("midreset_data", {32'd0, out_data}, 64'd0);
    check("midreset_cmd", {56'd0, out_cmd}, 64'd0);
    check("midreset_index", {62'd0, out_index}, 64'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    push_data(32'hCAFEBABE, 2'd0, 1'b0);
    send_frame(32'hCAFEBABE);

    // Drain with a bounded wait
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
